// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed little-endian byte stream into instruction memory writes,
// holding the core in reset until the whole image has been written.
module imem_loader #(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       buf_q, buf_d;
  logic [15:0]       n_q, n_d, word_idx_q, word_idx_d, words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, word;
  logic              ready_q, ready_d, we_q, we_d, crst_q, crst_d, done_q, done_d, err_q, err_d;
  logic              acc, last;
  always_comb begin
    acc        = in_valid && ready_q;
    last       = acc && byte_idx_q == 2'd3;
    word       = {in_data, buf_q};
    state_d    = state_q;
    byte_idx_d = acc ? byte_idx_q + 2'd1 : byte_idx_q;
    // shift register: after three accepted bytes buf_q holds {b2, b1, b0}
    buf_d      = acc ? {in_data, buf_q[23:8]} : buf_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    words_d    = words_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: state_d = S_LEN;
      S_LEN: if (last) begin
        state_d = word == 32'd0 ? S_DONE : word > 32'(DEPTH_WORDS) ? S_ERR : S_DATA;
        n_d     = word[15:0];
      end
      S_DATA: if (last) begin
        state_d = S_WRITE;
        addr_d  = BASE_ADDR + (ADDR_W'(word_idx_q) << 2);
        wdata_d = word;
      end
      S_WRITE: begin
        state_d    = word_idx_q + 16'd1 == n_q ? S_DONE : S_DATA;
        word_idx_d = word_idx_q + 16'd1;
        words_d    = words_q + 16'd1;
      end
      default: ;
    endcase
    ready_d = state_d == S_LEN || state_d == S_DATA;
    we_d    = state_d == S_WRITE;
    crst_d  = state_d == S_DONE;
    done_d  = state_d == S_DONE;
    err_d   = state_d == S_ERR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      buf_q      <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      words_q    <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      crst_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      crst_q     <= crst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  assign in_ready     = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_rst_n   = crst_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of two loader instances (256 words at 0x0, 4 words at 0x100).
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        vld [2];
  logic [7:0]  dat [2];
  logic        rdy [2], we [2], crst [2], dn [2], er [2];
  logic [31:0] ad [2], wd [2];
  logic [15:0] wl [2];
  int          nw [2] = '{0, 0};
  int          nacc [2] = '{0, 0};
  logic [31:0] wa [2][16];
  logic [31:0] wdv [2][16];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(32), .DEPTH_WORDS(256), .BASE_ADDR(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(vld[0]), .in_data(dat[0]), .in_ready(rdy[0]),
    .imem_we(we[0]), .imem_addr(ad[0]), .imem_wdata(wd[0]), .core_rst_n(crst[0]),
    .done(dn[0]), .error(er[0]), .words_loaded(wl[0]));

  imem_loader #(.ADDR_W(32), .DEPTH_WORDS(4), .BASE_ADDR(32'h100)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(vld[1]), .in_data(dat[1]), .in_ready(rdy[1]),
    .imem_we(we[1]), .imem_addr(ad[1]), .imem_wdata(wd[1]), .core_rst_n(crst[1]),
    .done(dn[1]), .error(er[1]), .words_loaded(wl[1]));

  // write log and accepted-byte count, sampled mid-cycle
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        if (nw[i] < 16) begin
          wa[i][nw[i]]  = ad[i];
          wdv[i][nw[i]] = wd[i];
        end
        nw[i]++;
      end
      if (vld[i] && rdy[i]) nacc[i]++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] b, input bit bub);
    int t = 0;
    if (bub) begin
      vld[i] = 1'b0;
      dat[i] = 8'($urandom);
      cyc(1);
    end
    vld[i] = 1'b1;
    dat[i] = b;
    @(negedge clk);
    while (!rdy[i] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[i]) chk("ready_timeout", {31'b0, rdy[i]}, 32'd1);
    cyc(1);
    vld[i] = 1'b0;
  endtask

  task automatic send_w(input int i, input logic [31:0] w, input bit bub);
    for (int k = 0; k < 4; k++) send(i, w[8*k +: 8], bub);
  endtask

  task automatic rst(input int i);
    rst_n[i] = 1'b0;
    cyc(1);
    rst_n[i] = 1'b1;
  endtask

  initial begin
    int n0, a0;
    logic [31:0] bw [4];
    bw = '{32'h00000013, 32'h00100093, 32'hFFFFFFFF, 32'h12345678};
    rst_n = '{1'b1, 1'b1};
    vld   = '{1'b0, 1'b0};
    dat   = '{8'h00, 8'h00};
    #2;
    rst_n = '{1'b0, 1'b0};
    #1;
    chk("rst_ready", {31'b0, rdy[0]}, 32'd0);
    chk("rst_we", {31'b0, we[0]}, 32'd0);
    chk("rst_addr", ad[0], 32'h0);
    chk("rst_wdata", wd[0], 32'h0);
    chk("rst_core", {31'b0, crst[0]}, 32'd0);
    chk("rst_done", {31'b0, dn[0]}, 32'd0);
    chk("rst_err", {31'b0, er[0]}, 32'd0);
    chk("rst_words", {16'b0, wl[0]}, 32'd0);
    chk("rst_addr_b", ad[1], 32'h100);
    cyc(2);
    rst_n = '{1'b1, 1'b1};
    chk("idle_ready", {31'b0, rdy[0]}, 32'd0);
    cyc(1);
    chk("len_ready", {31'b0, rdy[0]}, 32'd1);

    // normal load, valid held high
    n0 = nw[0]; a0 = nacc[0];
    send_w(0, 32'd2, 1'b0);
    send_w(0, 32'h00500093, 1'b0);
    send_w(0, 32'h00A00113, 1'b0);
    chk("norm_we_last", {31'b0, we[0]}, 32'd1);
    chk("norm_done_early", {31'b0, dn[0]}, 32'd0);
    chk("norm_words_mid", {16'b0, wl[0]}, 32'd1);
    cyc(1);
    chk("norm_done", {31'b0, dn[0]}, 32'd1);
    chk("norm_core", {31'b0, crst[0]}, 32'd1);
    chk("norm_words", {16'b0, wl[0]}, 32'd2);
    chk("norm_we_off", {31'b0, we[0]}, 32'd0);
    chk("norm_nwr", 32'(nw[0] - n0), 32'd2);
    chk("norm_a0", wa[0][n0], 32'h0);
    chk("norm_d0", wdv[0][n0], 32'h00500093);
    chk("norm_a1", wa[0][n0+1], 32'h4);
    chk("norm_d1", wdv[0][n0+1], 32'h00A00113);
    chk("norm_acc", 32'(nacc[0] - a0), 32'd12);

    // empty image
    rst(0);
    n0 = nw[0];
    send_w(0, 32'd0, 1'b0);
    chk("empty_done", {31'b0, dn[0]}, 32'd1);
    chk("empty_core", {31'b0, crst[0]}, 32'd1);
    chk("empty_words", {16'b0, wl[0]}, 32'd0);
    chk("empty_nwr", 32'(nw[0] - n0), 32'd0);
    chk("empty_ready", {31'b0, rdy[0]}, 32'd0);

    // length with nonzero upper byte
    rst(0);
    send_w(0, 32'h01000000, 1'b0);
    chk("upper_err", {31'b0, er[0]}, 32'd1);

    // oversize N=257, then further bytes refused
    rst(0);
    n0 = nw[0]; a0 = nacc[0];
    send_w(0, 32'd257, 1'b0);
    chk("over_err", {31'b0, er[0]}, 32'd1);
    chk("over_done", {31'b0, dn[0]}, 32'd0);
    chk("over_core", {31'b0, crst[0]}, 32'd0);
    chk("over_ready", {31'b0, rdy[0]}, 32'd0);
    vld[0] = 1'b1;
    dat[0] = 8'h55;
    cyc(5);
    vld[0] = 1'b0;
    chk("over_acc", 32'(nacc[0] - a0), 32'd4);
    chk("over_nwr", 32'(nw[0] - n0), 32'd0);

    // bubbles on valid with random data
    rst(0);
    n0 = nw[0]; a0 = nacc[0];
    send_w(0, 32'd2, 1'b1);
    send_w(0, 32'h00500093, 1'b1);
    send_w(0, 32'h00A00113, 1'b1);
    cyc(1);
    chk("bub_nwr", 32'(nw[0] - n0), 32'd2);
    chk("bub_a0", wa[0][n0], 32'h0);
    chk("bub_d0", wdv[0][n0], 32'h00500093);
    chk("bub_a1", wa[0][n0+1], 32'h4);
    chk("bub_d1", wdv[0][n0+1], 32'h00A00113);
    chk("bub_acc", 32'(nacc[0] - a0), 32'd12);
    chk("bub_done", {31'b0, dn[0]}, 32'd1);

    // reset in the middle of word 0, then reload
    rst(0);
    send_w(0, 32'd1, 1'b0);
    send(0, 8'hEF, 1'b0);
    send(0, 8'hBE, 1'b0);
    chk("mid_ready_pre", {31'b0, rdy[0]}, 32'd1);
    rst_n[0] = 1'b0;
    #1;
    chk("mid_ready", {31'b0, rdy[0]}, 32'd0);
    chk("mid_core", {31'b0, crst[0]}, 32'd0);
    chk("mid_done", {31'b0, dn[0]}, 32'd0);
    chk("mid_words", {16'b0, wl[0]}, 32'd0);
    chk("mid_we", {31'b0, we[0]}, 32'd0);
    cyc(1);
    rst_n[0] = 1'b1;
    n0 = nw[0];
    send_w(0, 32'd1, 1'b0);
    send_w(0, 32'hDEADBEEF, 1'b0);
    cyc(1);
    chk("reload_nwr", 32'(nw[0] - n0), 32'd1);
    chk("reload_a", wa[0][n0], 32'h0);
    chk("reload_d", wdv[0][n0], 32'hDEADBEEF);
    chk("reload_done", {31'b0, dn[0]}, 32'd1);
    chk("reload_words", {16'b0, wl[0]}, 32'd1);

    // full depth on the 4-word instance
    n0 = nw[1];
    send_w(1, 32'd4, 1'b0);
    for (int k = 0; k < 4; k++) send_w(1, bw[k], 1'b0);
    cyc(1);
    chk("full_nwr", 32'(nw[1] - n0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_a%0d", k), wa[1][n0+k], 32'h100 + 32'(4*k));
      chk($sformatf("full_d%0d", k), wdv[1][n0+k], bw[k]);
    end
    chk("full_words", {16'b0, wl[1]}, 32'd4);
    chk("full_done", {31'b0, dn[1]}, 32'd1);
    rst(1);
    n0 = nw[1];
    send_w(1, 32'd5, 1'b0);
    chk("full5_err", {31'b0, er[1]}, 32'd1);
    chk("full5_done", {31'b0, dn[1]}, 32'd0);
    chk("full5_nwr", 32'(nw[1] - n0), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
